booth_mult_n: RTL and testbench

BOOTH_MULT_N -- requirements
Module: booth_mult_n

---
 rtl/mult_pkg.sv | 20 ++
 rtl/booth_step.sv | 32 +++
 rtl/booth_mult_n.sv | 109 ++++++++++
 tb/tb_booth_mult_n.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states,
// Booth operation encoding and the default operand width.
package mult_pkg;

  localparam int MULT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;

  // Radix-2 Booth recoding of the {Q0, Q-1} bit pair.
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: optional add/subtract of the
// multiplicand into A, then arithmetic shift of {A,Q,Q-1} right by one.
module booth_step
  import mult_pkg::*;
#(
  parameter int XW = MULT_WIDTH_DEF + 1
) (
  input  logic [XW-1:0] a,
  input  logic [XW-1:0] q,
  input  logic          qm1,
  input  logic [XW-1:0] m,
  output logic [XW-1:0] a_nxt,
  output logic [XW-1:0] q_nxt,
  output logic          qm1_nxt
);

  booth_op_t     op;
  logic [XW-1:0] sum;

  always_comb begin
    op = booth_decode(q[0], qm1);
    case (op)
      ADD:     sum = a + m;
      SUB:     sum = a - m;
      default: sum = a;
    endcase
    a_nxt   = {sum[XW-1], sum[XW-1:1]};
    q_nxt   = {sum[0], q[XW-1:1]};
    qm1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mult_n.sv
// Sequential WIDTH x WIDTH Booth multiplier, one step per cycle on
// WIDTH+1-bit extended operands. Define BOOTH_MULT_UNSIGNED_EN to honour mult_signed.
module booth_mult_n
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             mult_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mult_hi,
  output logic [WIDTH-1:0] mult_lo
);

  localparam int XW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]  a_q, a_d, q_q, q_d, m_q, m_d;
  logic           qm1_q, qm1_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XW-1:0]  a_nxt, q_nxt;
  logic           qm1_nxt;
  logic           sgn;

  booth_step #(.XW(XW)) u_step (
    .a       (a_q),
    .q       (q_q),
    .qm1     (qm1_q),
    .m       (m_q),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .qm1_nxt (qm1_nxt)
  );

  always_comb begin
`ifdef BOOTH_MULT_UNSIGNED_EN
    sgn = mult_signed;
`else
    // Port kept for interface compatibility; operands are always signed here.
    sgn = mult_signed | 1'b1;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      RUN: begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        qm1_d = qm1_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH)) begin
          state_d      = DONE;
          {hi_d, lo_d} = {a_nxt[WIDTH-2:0], q_nxt};
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = '0;
          qm1_d   = 1'b0;
          m_d     = {sgn & multiplicand[WIDTH-1], multiplicand};
          q_d     = {sgn & multiplier[WIDTH-1], multiplier};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign mult_hi = hi_q;
  assign mult_lo = lo_q;

endmodule

// File: tb/tb_booth_mult_n.sv
// Scoreboard bench for booth_mult_n (WIDTH=32): expected products are queued
// at accept time and compared, with latency, on each done pulse.
module tb_booth_mult_n;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset, start, mult_signed;
  logic [W-1:0]  multiplicand, multiplier;
  logic          busy, done;
  logic [W-1:0]  mult_hi, mult_lo;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [63:0]   exp_q[$];
  int            acc_q[$];
  logic [63:0]   prev_res;
  logic          prev_busy = 1'b0;

  booth_mult_n #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .mult_signed  (mult_signed),
    .busy         (busy),
    .done         (done),
    .mult_hi      (mult_hi),
    .mult_lo      (mult_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic s);
    logic eff;
    eff = s;
`ifndef BOOTH_MULT_UNSIGNED_EN
    eff = 1'b1;
`endif
    if (eff) return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    else     return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Monitor: compare on done, and verify outputs hold steady during RUN.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          logic [63:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("hi", {32'd0, mult_hi}, {32'd0, e[63:32]});
          chk("lo", {32'd0, mult_lo}, {32'd0, e[31:0]});
          chk("latency", 64'(cyc - a), 64'(LAT));
        end
      end
      if (busy && prev_busy) chk("hold_in_run", {mult_hi, mult_lo}, prev_res);
    end
    prev_busy = busy;
    prev_res  = {mult_hi, mult_lo};
  end

  // Called at a negedge where the DUT is not busy; the next edge accepts.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    chk("ready", {63'd0, busy}, 64'd0);
    start = 1'b1; multiplicand = a; multiplier = b; mult_signed = s;
    @(posedge clk); #1;
    exp_q.push_back(model(a, b, s));
    acc_q.push_back(cyc);
    start = 1'b0;
    multiplicand = $urandom; multiplier = $urandom; mult_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    wait_idle();
    issue(a, b, s);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mult_signed = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, mult_hi}, 64'd0);
    chk("rst_lo", {32'd0, mult_lo}, 64'd0);
    reset = 1'b0;

    run(32'd7, 32'hFFFF_FFFD, 1'b1);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run(32'h8000_0000, 32'h8000_0000, 1'b1);
    run(32'h8000_0000, 32'd1, 1'b1);
    run(32'd1, 32'h8000_0000, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // start during RUN must be ignored
    run(32'd5, 32'd6, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
    repeat (3) @(negedge clk);
    start = 1'b0;

    // back-to-back start in the DONE cycle
    wait_idle();
    issue(32'd5, 32'd6, 1'b1);
    begin
      int n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("done_timeout", 64'd1, 64'd0);
    end
    issue(32'd9, 32'd9, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run($urandom, $urandom, 1'(i % 2));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // abort mid-operation with reset
    run(32'd123, 32'd456, 1'b1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    acc_q.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hi", {32'd0, mult_hi}, 64'd0);
    chk("abort_lo", {32'd0, mult_lo}, 64'd0);
    issue(32'd2, 32'd3, 1'b1);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("drain", 64'(exp_q.size()), 64'd0);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
